// File: rtl/calc2_port_responder.sv
// Reference responder for one Calc2 request port. It takes two-cycle cmd/data/tag requests,
// computes add/sub/shift results and returns each response in order on its scheduled due cycle.
module calc2_port_responder #(
    parameter int LATENCY = 3,
    parameter int DEPTH   = 4
) (
    input  logic        clk,
    input  logic        resetInt,
    input  logic [0:3]  cmd_in,
    input  logic [0:31] data_in,
    input  logic [0:1]  tag_in,
    output logic [0:1]  out_resp,
    output logic [0:31] out_data,
    output logic [0:1]  out_tag,
    output logic        busy,
    output logic        err_drop
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = 6;

    typedef enum logic {IDLE, OP2} state_t;

    typedef struct packed {
        logic [1:0]    resp;
        logic [31:0]   data;
        logic [1:0]    tag;
        logic [CW-1:0] due;
    } entry_t;

    state_t        state, state_next;
    logic [3:0]    cmd_q;
    logic [1:0]    tag_q;
    logic [31:0]   op1_q;
    logic [31:0]   op2;
    logic [32:0]   sum;
    logic [CW-1:0] cyc;

    entry_t        fifo [DEPTH];
    entry_t        new_entry;
    entry_t        head;
    logic [PW-1:0] rd_ptr, wr_ptr, scan_idx;
    logic [PW:0]   count, count_after;

    logic [CW-1:0] due_base, tail_next, gap, slack;
    logic          enq_req, pop, push, drop, bypass, write_en, tag_hit, full;

    assign op2 = data_in;

    always_ff @(posedge clk or posedge resetInt) begin
        if (resetInt) state <= IDLE;
        else          state <= state_next;
    end

    // NOTE: every signal driven here gets a default first so no latch can be inferred.
    always_comb begin
        state_next = IDLE;
        enq_req    = 1'b0;
        case (state)
            IDLE:    state_next = (cmd_in != 4'd0) ? OP2 : IDLE;
            OP2:     enq_req    = 1'b1;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state is updated only with non-blocking assignments.
    always_ff @(posedge clk or posedge resetInt) begin
        if (resetInt) begin
            cmd_q <= '0;
            tag_q <= '0;
            op1_q <= '0;
            cyc   <= '0;
        end else begin
            cyc <= cyc + CW'(1);
            if (state == IDLE && cmd_in != 4'd0) begin
                cmd_q <= cmd_in;
                tag_q <= tag_in;
                op1_q <= data_in;
            end
        end
    end

    // Result and due cycle of the request completing in this OP2 cycle.
    always_comb begin
        sum            = {1'b0, op1_q} + {1'b0, op2};
        new_entry      = '0;
        new_entry.tag  = tag_q;
        new_entry.resp = 2'b10;
        if (cmd_in != 4'd0) begin
            new_entry.resp = 2'b11;
        end else begin
            case (cmd_q)
                4'd1: if (!sum[32]) begin
                    new_entry.resp = 2'b01;
                    new_entry.data = sum[31:0];
                end
                4'd2: if (op2 <= op1_q) begin
                    new_entry.resp = 2'b01;
                    new_entry.data = op1_q - op2;
                end
                4'd5: begin
                    new_entry.resp = 2'b01;
                    new_entry.data = op1_q << op2[4:0];
                end
                4'd6: begin
                    new_entry.resp = 2'b01;
                    new_entry.data = op1_q >> op2[4:0];
                end
                default: ;
            endcase
        end
        due_base      = cyc + CW'(LATENCY);
        tail_next     = fifo[wr_ptr - PW'(1)].due + CW'(1);
        gap           = tail_next - due_base;
        new_entry.due = (count != '0 && !gap[CW-1] && gap != '0) ? tail_next : due_base;
    end

    // Due compare is relative so the 6-bit cycle counter may wrap freely.
    assign head  = fifo[rd_ptr];
    assign slack = head.due - (cyc + CW'(1));
    assign pop   = (count != '0) && (slack[CW-1] || slack == '0);

    always_comb begin
        tag_hit  = 1'b0;
        scan_idx = rd_ptr;
        for (int k = 0; k < DEPTH; k++) begin
            scan_idx = rd_ptr + PW'(k);
            if ((PW+1)'(k) < count && !(pop && k == 0) && fifo[scan_idx].tag == tag_q)
                tag_hit = 1'b1;
        end
    end

    assign count_after = count - (PW+1)'(pop);
    assign full        = (count_after == (PW+1)'(DEPTH));
    assign drop        = enq_req && (full || tag_hit);
    assign push        = enq_req && !drop;
    // Only reachable with LATENCY 1: the entry is due before it could leave the queue.
    assign bypass      = push && (count == '0) && (new_entry.due == cyc + CW'(1));
    assign write_en    = push && !bypass;

    always_ff @(posedge clk or posedge resetInt) begin
        if (resetInt) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            rd_ptr <= rd_ptr + PW'(pop);
            wr_ptr <= wr_ptr + PW'(write_en);
            count  <= count_after + (PW+1)'(write_en);
        end
    end

    // NOTE: queue storage is not reset; only entries counted by count are ever read as valid.
    always_ff @(posedge clk) begin
        if (write_en) fifo[wr_ptr] <= new_entry;
    end

    always_ff @(posedge clk or posedge resetInt) begin
        if (resetInt) begin
            out_resp <= '0;
            out_data <= '0;
            out_tag  <= '0;
            err_drop <= 1'b0;
        end else begin
            err_drop <= err_drop | drop;
            if (pop) begin
                out_resp <= head.resp;
                out_data <= head.data;
                out_tag  <= head.tag;
            end else if (bypass) begin
                out_resp <= new_entry.resp;
                out_data <= new_entry.data;
                out_tag  <= new_entry.tag;
            end else begin
                out_resp <= '0;
                out_data <= '0;
                out_tag  <= '0;
            end
        end
    end

    assign busy = (state == OP2) || (count != '0);

endmodule

// File: tb/tb_calc2_port_responder.sv
// Scoreboard bench for calc2_port_responder: randomized requests against a cycle-level reference
// model; a negedge monitor compares every cycle's outputs, busy and err_drop.
module tb_calc2_port_responder;

    localparam int LATENCY = 7;
    localparam int DEPTH   = 2;
    localparam int BIG     = 1 << 30;

    logic        clk = 1'b0;
    logic        resetInt;
    logic [0:3]  cmd_in;
    logic [0:31] data_in;
    logic [0:1]  tag_in;
    logic [0:1]  out_resp;
    logic [0:31] out_data;
    logic [0:1]  out_tag;
    logic        busy;
    logic        err_drop;

    always #5 clk = ~clk;

    calc2_port_responder #(.LATENCY(LATENCY), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .resetInt (resetInt),
        .cmd_in   (cmd_in),
        .data_in  (data_in),
        .tag_in   (tag_in),
        .out_resp (out_resp),
        .out_data (out_data),
        .out_tag  (out_tag),
        .busy     (busy),
        .err_drop (err_drop)
    );

    typedef struct {
        logic [1:0]  resp;
        logic [31:0] data;
        logic [1:0]  tag;
        int          enq;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   cycle    = 0;
    int   checks   = 0;
    int   failures = 0;
    int   last_due = -1000;
    int   err_from = BIG;
    int   op2_at   = -1;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=0x%0h expected=0x%0h", name, cycle, act, exp);
        end
    endtask

    // Arithmetic rules of the port, stated directly on unsigned values.
    function automatic void calc(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                                 input bit proto, output logic [1:0] resp, output logic [31:0] data);
        logic [63:0] s;
        resp = 2'd2;
        data = '0;
        s    = {32'd0, a} + {32'd0, b};
        if (proto) resp = 2'd3;
        else case (cmd)
            4'd1: if (s <= 64'hFFFF_FFFF) begin resp = 2'd1; data = s[31:0]; end
            4'd2: if (b <= a) begin resp = 2'd1; data = a - b; end
            4'd5: begin resp = 2'd1; data = a << (b % 32); end
            4'd6: begin resp = 2'd1; data = a >> (b % 32); end
            default: ;
        endcase
    endfunction

    // Called in op2 cycle t: entries due at t+1 leave the queue on the same edge this one arrives.
    task automatic model_enqueue(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                                 input logic [1:0] tag, input bit proto, input int t);
        exp_t e;
        int   outstanding = 0;
        bit   hit = 0;
        calc(cmd, a, b, proto, e.resp, e.data);
        foreach (sb[i]) if (sb[i].due > t + 1) begin
            outstanding++;
            if (sb[i].tag == tag) hit = 1;
        end
        if (outstanding >= DEPTH || hit) begin
            if (err_from > t + 1) err_from = t + 1;
        end else begin
            e.tag    = tag;
            e.enq    = t + 1;
            e.due    = (t + LATENCY > last_due + 1) ? t + LATENCY : last_due + 1;
            last_due = e.due;
            sb.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        logic [1:0]  er;
        logic [31:0] ed;
        logic [1:0]  et;
        logic        eb;
        er = '0;
        ed = '0;
        et = '0;
        eb = (op2_at == cycle);
        foreach (sb[i]) if (sb[i].enq <= cycle && cycle < sb[i].due) eb = 1'b1;
        if (sb.size() > 0 && sb[0].due == cycle) begin
            er = sb[0].resp;
            ed = sb[0].data;
            et = sb[0].tag;
            void'(sb.pop_front());
        end
        check("out_resp", 32'(out_resp), 32'(er));
        check("out_data", out_data, ed);
        check("out_tag", 32'(out_tag), 32'(et));
        check("busy", 32'(busy), 32'(eb));
        check("err_drop", 32'(err_drop), 32'(cycle >= err_from));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            cmd_in  = 4'd0;
            data_in = $urandom;
            tag_in  = 2'($urandom);
        end
    endtask

    task automatic send(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] tag, input logic [3:0] cmd2);
        step();
        cmd_in  = cmd;
        data_in = a;
        tag_in  = tag;
        step();
        cmd_in  = cmd2;
        data_in = b;
        tag_in  = 2'($urandom);
        op2_at  = cycle;
        model_enqueue(cmd, a, b, tag, cmd2 != 4'd0, cycle);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        resetInt = 1'b1;
        cmd_in   = 4'd0;
        sb.delete();
        err_from = BIG;
        op2_at   = -1;
        last_due = -1000;
        repeat (2) @(posedge clk);
        #3;
        resetInt = 1'b0;
    endtask

    function automatic logic [31:0] rand_op();
        case ($urandom_range(0, 3))
            0:       return $urandom;
            1:       return 32'hFFFF_FFFF - $urandom_range(0, 3);
            2:       return $urandom_range(0, 40);
            default: return 32'h8000_0000;
        endcase
    endfunction

    function automatic logic [3:0] rand_cmd();
        logic [3:0] c;
        case ($urandom_range(0, 9))
            0, 1, 9: c = 4'd1;
            2, 3:    c = 4'd2;
            4, 5:    c = 4'd5;
            6, 7:    c = 4'd6;
            default: begin
                c = 4'($urandom_range(3, 15));
                if (c == 4'd5 || c == 4'd6) c = 4'd7;
            end
        endcase
        return c;
    endfunction

    initial begin
        resetInt = 1'b1;
        cmd_in   = 4'd0;
        data_in  = '0;
        tag_in   = '0;
        repeat (3) @(posedge clk);
        #3;
        resetInt = 1'b0;
        idle(2);

        send(4'd1, 32'h0000_0005, 32'h0000_0003, 2'd1, 4'd0);
        idle(9);
        send(4'd1, 32'hFFFF_FFFF, 32'h0000_0001, 2'd2, 4'd0);
        idle(9);
        send(4'd2, 32'd3, 32'd5, 2'd3, 4'd0);
        idle(9);
        send(4'd5, 32'h0000_0001, 32'h0000_0024, 2'd0, 4'd0);
        idle(9);
        send(4'd6, 32'h8000_0000, 32'd31, 2'd1, 4'd0);
        idle(9);
        send(4'd4, 32'd9, 32'd9, 2'd2, 4'd0);
        idle(9);
        send(4'd1, 32'd10, 32'd20, 2'd2, 4'd2);
        idle(9);

        // Tag reuse while the first is still queued, then a back-to-back burst that fills the queue.
        send(4'd1, 32'd1, 32'd1, 2'd0, 4'd0);
        send(4'd1, 32'd2, 32'd2, 2'd0, 4'd0);
        idle(12);
        for (int i = 0; i < 5; i++) send(4'd1, 32'(i), 32'd100, 2'(i), 4'd0);
        idle(12);

        // Reset between op2 and due cycle flushes the request and clears err_drop.
        send(4'd1, 32'd7, 32'd7, 2'd1, 4'd0);
        idle(2);
        do_reset();
        idle(12);

        for (int i = 0; i < 400; i++) begin
            if (i == 200) do_reset();
            idle($urandom_range(0, 3));
            send(rand_cmd(), rand_op(), rand_op(), 2'($urandom),
                 ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : 4'd0);
        end
        idle(LATENCY + 2 * DEPTH + 10);
        check("queue_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
